// File: rtl/sram6168_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sram6168_pkg
//  Brief   : Shared types and constants for the IDT6168A access controller.
//  Rev     : 1.0  initial release
// ============================================================================
package sram6168_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } sram_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sram_sweep_counter
//  Brief   : Clear-sweep address counter; saturates at all-ones (tc).
//  Rev     : 1.0  initial release
// ============================================================================
module sram_sweep_counter
  import sram6168_pkg::*;
#(
  parameter int WIDTH = SRAM_ADDR_W
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  assign tc = &cnt;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram6168_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : sram6168_ctrl
//  Brief   : Single-request access sequencer and power-up clear for a 4K x 4
//            IDT6168A SRAM; all SRAM strobes come straight from flops.
//  Rev     : 1.0  initial release
// ============================================================================
module sram6168_ctrl
  import sram6168_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int WAIT_CYCLES  = 1,
  parameter int CLR_ON_RESET = 1
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  input  logic              clr_start,
  output logic              clr_done,
  output logic [ADDR_W-1:0] A_11_0,
  output logic              CE_n,
  output logic              WE_n,
  output logic [DATA_W-1:0] D_out,
  output logic              D_oe,
  input  logic [DATA_W-1:0] D_in
);

  localparam logic [2:0] c_waitLast = 3'(WAIT_CYCLES);
  localparam logic       c_clrInit  = (CLR_ON_RESET != 0);

  sram_state_t       r_state;
  sram_state_t       w_next;
  logic              r_clrPend;
  logic              r_clrMode;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_wait;

  logic              w_load;
  logic              w_ldWe;
  logic [DATA_W-1:0] w_ldData;
  logic [ADDR_W-1:0] w_ldAddr;
  logic              w_opWe;
  logic              w_clrSet;
  logic              w_clrEnd;
  logic              w_swClr;
  logic              w_swInc;
  logic              w_waitClr;
  logic              w_waitInc;
  logic              w_ackNext;
  logic              w_doneNext;
  logic              w_capture;
  logic [ADDR_W-1:0] w_swCnt;
  logic              w_swTc;

  sram_sweep_counter #(.WIDTH(ADDR_W)) u_sweep (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .clr       (w_swClr),
    .inc       (w_swInc),
    .cnt       (w_swCnt),
    .tc        (w_swTc)
  );

  assign busy   = (r_state != ST_IDLE) | r_clrPend | r_clrMode;
  assign w_opWe = w_load ? w_ldWe : r_we;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_ldWe     = r_we;
    w_ldData   = r_wdata;
    w_ldAddr   = A_11_0;
    w_clrSet   = 1'b0;
    w_clrEnd   = 1'b0;
    w_swClr    = 1'b0;
    w_swInc    = 1'b0;
    w_waitClr  = 1'b0;
    w_waitInc  = 1'b0;
    w_ackNext  = 1'b0;
    w_doneNext = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // a clear sweep wins over a request in the same cycle
        if (r_clrPend || clr_start) begin
          w_next   = ST_SETUP;
          w_clrSet = 1'b1;
          w_swClr  = 1'b1;
          w_load   = 1'b1;
          w_ldWe   = 1'b1;
          w_ldData = '0;
          w_ldAddr = '0;
        end else if (req) begin
          w_next   = ST_SETUP;
          w_load   = 1'b1;
          w_ldWe   = we;
          w_ldData = wdata;
          w_ldAddr = addr;
        end
      end
      ST_SETUP: begin
        w_next    = ST_STROBE;
        w_waitClr = 1'b1;
      end
      ST_STROBE: begin
        if (r_wait == c_waitLast) begin
          w_next     = ST_RECOVER;
          w_capture  = !r_we;
          w_ackNext  = !r_clrMode;
          w_doneNext = r_clrMode && w_swTc;
        end else begin
          w_waitInc = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (r_clrMode && !w_swTc) begin
          // next sweep word goes straight to SETUP, skipping IDLE
          w_next   = ST_SETUP;
          w_swInc  = 1'b1;
          w_load   = 1'b1;
          w_ldWe   = 1'b1;
          w_ldData = '0;
          w_ldAddr = w_swCnt + 1'b1;
        end else begin
          w_next   = ST_IDLE;
          w_clrEnd = r_clrMode;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_clrPend <= c_clrInit;
      r_clrMode <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_wait    <= '0;
      A_11_0    <= '0;
      CE_n      <= 1'b1;
      WE_n      <= 1'b1;
      D_out     <= '0;
      D_oe      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
      clr_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clrSet) begin
        r_clrPend <= 1'b0;
        r_clrMode <= 1'b1;
      end else if (w_clrEnd) begin
        r_clrMode <= 1'b0;
      end
      if (w_waitClr) begin
        r_wait <= '0;
      end else if (w_waitInc) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_load) begin
        r_we    <= w_ldWe;
        r_wdata <= w_ldData;
        A_11_0  <= w_ldAddr;
        if (w_ldWe) begin
          D_out <= w_ldData;
        end
      end
      // strobes are registered from the next state so they never glitch
      CE_n     <= (w_next == ST_IDLE);
      WE_n     <= !((w_next == ST_STROBE) && w_opWe);
      D_oe     <= (w_next != ST_IDLE) && w_opWe;
      ack      <= w_ackNext;
      clr_done <= w_doneNext;
      if (w_capture) begin
        rdata <= D_in;
      end
    end
  end

endmodule
`default_nettype wire
